fwd_hazard_ctrl: RTL and testbench

//   Forwarding/hazard controller for the 5-stage RISC-V pipeline. Generates the

---
 rtl/fwd_hazard_ctrl_pkg.sv | 28 ++
 rtl/fwd_hazard_ctrl_if.sv | 55 +++++
 rtl/fwd_hazard_ctrl_pipe_tag_reg.sv | 28 ++
 rtl/fwd_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl_pkg
//   Shared types for the forwarding/hazard controller of the 5-stage pipeline.
//   fwd_sel_t   : EX operand mux3 select (d0=regfile, d1=WB result, d2=MEM ALU)
//   pipe_tag_t  : shadow destination tag carried EX -> MEM -> WB
//   TAG_BUBBLE  : all-zero tag used for bubbles, flushes and reset
//   TAG_RD_W    : register index width stored in a tag
// -----------------------------------------------------------------------------
package fwd_hazard_ctrl_pkg;

  localparam int TAG_RD_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } pipe_tag_t;

  localparam pipe_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl_if
//   Bundles the ID-stage decode information and the controller outputs.
//   master : pipeline side (drives id_*/flush, receives selects and stall)
//   slave  : controller side
//   Signals: id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
//            id_regwrite, id_memread, flush  (pipeline -> controller)
//            fwd_a, fwd_b, stall             (controller -> pipeline)
//            stall_cnt, fwd_cnt              (only with HAZARD_PERF_CNT_EN)
// -----------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  flush;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  stall;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      fwd_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, flush,
    input  fwd_a, fwd_b, stall, stall_cnt, fwd_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, flush,
    output fwd_a, fwd_b, stall, stall_cnt, fwd_cnt
  );
`else
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, flush,
    input  fwd_a, fwd_b, stall
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, flush,
    output fwd_a, fwd_b, stall
  );
`endif
endinterface

// File: rtl/fwd_hazard_ctrl_pipe_tag_reg.sv
// -----------------------------------------------------------------------------
// pipe_tag_reg
//   One shadow pipeline stage: registers a destination tag, cleared to a
//   bubble by synchronous reset.
//   clk     in  pipeline clock
//   reset   in  synchronous active-high clear
//   tag_d_i in  tag entering this stage
//   tag_q_o out tag currently held by this stage
// -----------------------------------------------------------------------------
module pipe_tag_reg
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  pipe_tag_t tag_d_i,
  output pipe_tag_t tag_q_o
);

  pipe_tag_t tag_q;

  always_ff @(posedge clk) begin
    if (reset) tag_q <= TAG_BUBBLE;
    else       tag_q <= tag_d_i;
  end

  assign tag_q_o = tag_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Forwarding/hazard controller for the 5-stage RISC-V pipeline. Produces the
//   registered EX operand mux3 selects (fwd_a/fwd_b) and the combinational
//   load-use stall, tracking destination tags in its own EX/MEM/WB shadow pipe.
//   Ports:
//     clk    in  pipeline clock
//     reset  in  synchronous active-high reset
//     hz     fwd_hazard_ctrl_if.slave (ID decode info in; fwd_a/fwd_b/stall out)
//   Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall_cnt and
//   fwd_cnt performance counters on the interface.
//   REG_ADDR_W must equal fwd_hazard_ctrl_pkg::TAG_RD_W.
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic                 clk,
  input logic                 reset,
  fwd_hazard_ctrl_if.slave    hz
);

  logic [REG_ADDR_W-1:0] rs1_w, rs2_w, rd_w;
  logic [TAG_RD_W-1:0]   rs1, rs2;
  pipe_tag_t             ex_tag_d, ex_tag_q, mem_tag_q, wb_tag_q;
  logic                  stall, bubble;
  fwd_sel_t              fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;

  assign rs1_w = hz.id_rs1;
  assign rs2_w = hz.id_rs2;
  assign rd_w  = hz.id_rd;
  assign rs1   = TAG_RD_W'(rs1_w);
  assign rs2   = TAG_RD_W'(rs2_w);

  // The instruction now in EX moves to MEM on this edge, so an EX match
  // selects the MEM ALU result; likewise a MEM match selects the WB result.
  // A load in EX cannot be forwarded from MEM; the stall covers that case.
  function automatic fwd_sel_t sel_next(input pipe_tag_t ex, input pipe_tag_t mem,
                                        input logic [TAG_RD_W-1:0] rs,
                                        input logic use_rs);
    if (use_rs && ex.valid && ex.regwrite && !ex.memread &&
        ex.rd != '0 && ex.rd == rs)
      return FWD_MEM;
    else if (use_rs && mem.valid && mem.regwrite && mem.rd != '0 && mem.rd == rs)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // ID stage: load-use detection (flush wins) and the tag entering EX
  assign stall = hz.id_valid && !hz.flush && ex_tag_q.valid && ex_tag_q.memread &&
                 ex_tag_q.rd != '0 &&
                 ((hz.id_use_rs1 && ex_tag_q.rd == rs1) ||
                  (hz.id_use_rs2 && ex_tag_q.rd == rs2));
  assign bubble = stall || hz.flush || !hz.id_valid;

  always_comb begin
    ex_tag_d = TAG_BUBBLE;
    fwd_a_d  = FWD_RF;
    fwd_b_d  = FWD_RF;
    if (!bubble) begin
      ex_tag_d.valid    = 1'b1;
      ex_tag_d.rd       = TAG_RD_W'(rd_w);
      ex_tag_d.regwrite = hz.id_regwrite;
      ex_tag_d.memread  = hz.id_memread;
      fwd_a_d = sel_next(ex_tag_q, mem_tag_q, rs1, hz.id_use_rs1);
      fwd_b_d = sel_next(ex_tag_q, mem_tag_q, rs2, hz.id_use_rs2);
    end
  end

  // ID -> EX boundary: selects and shadow tags advance together
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  pipe_tag_reg u_ex_tag  (.clk(clk), .reset(reset), .tag_d_i(ex_tag_d),  .tag_q_o(ex_tag_q));
  pipe_tag_reg u_mem_tag (.clk(clk), .reset(reset), .tag_d_i(ex_tag_q),  .tag_q_o(mem_tag_q));
  pipe_tag_reg u_wb_tag  (.clk(clk), .reset(reset), .tag_d_i(mem_tag_q), .tag_q_o(wb_tag_q));

  // The regfile writes in the first half-cycle, so the WB tag never drives a
  // select; the stage is kept so the shadow pipe mirrors the real one.
  logic wb_tag_unused;
  assign wb_tag_unused = ^wb_tag_q;

  assign hz.fwd_a = fwd_a_q;
  assign hz.fwd_b = fwd_b_q;
  assign hz.stall = stall;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall) stall_cnt_d = sat_inc(stall_cnt_q);
    if (fwd_a_q != FWD_RF || fwd_b_q != FWD_RF) fwd_cnt_d = sat_inc(fwd_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       exp_stall;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    string      name;
  } vec_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  vec_t vecs[$];

  fwd_hazard_ctrl_if #(.REG_ADDR_W(5)) hif ();

  fwd_hazard_ctrl #(.REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic fl,
                              input logic st, input logic [1:0] a, input logic [1:0] b,
                              input string name);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.rw = rw; v.mr = mr; v.fl = fl; v.exp_stall = st; v.exp_a = a; v.exp_b = b;
    v.name = name;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hif.id_valid    = v.vld;
    hif.id_rs1      = v.rs1;
    hif.id_rs2      = v.rs2;
    hif.id_use_rs1  = v.u1;
    hif.id_use_rs2  = v.u2;
    hif.id_rd       = v.rd;
    hif.id_regwrite = v.rw;
    hif.id_memread  = v.mr;
    hif.flush       = v.fl;
  endtask

  // Drive at negedge, check stall mid-cycle, check selects just after posedge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    #2;
    chk({v.name, "_stall"}, 32'(hif.stall), 32'(v.exp_stall));
    @(posedge clk);
    #1;
    chk({v.name, "_fwd_a"}, 32'(hif.fwd_a), 32'(v.exp_a));
    chk({v.name, "_fwd_b"}, 32'(hif.fwd_b), 32'(v.exp_b));
  endtask

  task automatic add_nops(input int n);
    for (int i = 0; i < n; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "nop"));
  endtask

  initial begin
    vec_t v;
    n_chk  = 0;
    n_fail = 0;

    // add x5,x1,x2 ; add x6,x5,x3 -> MEM forward on A
    vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, "s1_add_x5"));
    vecs.push_back(mk(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, 2'b10, 2'b00, "s1_add_x6"));
    add_nops(3);
    // add x5 ; nop ; sub x7,x4,x5 -> WB forward on B
    vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, "s2_add_x5"));
    add_nops(1);
    vecs.push_back(mk(1, 4, 5, 1, 1, 7, 1, 0, 0, 0, 2'b00, 2'b01, "s2_sub_x7"));
    add_nops(3);
    // lw x5 ; add x6,x5,x5 -> one stall, then WB forward on both
    vecs.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, "s3_lw_x5"));
    vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00, "s3_add_stall"));
    vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 2'b01, 2'b01, "s3_add_fwd"));
    add_nops(3);
    // x0 never forwards
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, "s4_addi_x0"));
    vecs.push_back(mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, "s4_add_x0"));
    add_nops(3);
    // x5 in MEM and EX: MEM priority
    vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, "s5_add_x5_a"));
    vecs.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, "s5_add_x5_b"));
    vecs.push_back(mk(1, 9, 5, 1, 1, 8, 1, 0, 0, 0, 2'b00, 2'b10, "s5_prio"));
    add_nops(3);
    // flush beats load-use stall and inserts a bubble
    vecs.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, "s6_lw_x5"));
    vecs.push_back(mk(1, 5, 2, 1, 1, 6, 1, 0, 1, 0, 2'b00, 2'b00, "s6_flush"));
    vecs.push_back(mk(1, 6, 5, 1, 1, 7, 1, 0, 0, 0, 2'b00, 2'b01, "s6_after"));
    add_nops(3);
    // producer already in WB when consumer enters EX: regfile path
    vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, "s7_add_x5"));
    add_nops(2);
    vecs.push_back(mk(1, 5, 5, 1, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, "s7_wb_none"));
    add_nops(3);
    // use flags gate matching
    vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, "s8_add_x5"));
    vecs.push_back(mk(1, 5, 5, 0, 1, 9, 1, 0, 0, 0, 2'b00, 2'b10, "s8_use"));
    add_nops(3);
    // load to x0 never stalls
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, "s9_lw_x0"));
    vecs.push_back(mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, "s9_no_stall"));
    add_nops(3);
    // invalid ID slot never stalls
    vecs.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, "s10_lw_x5"));
    vecs.push_back(mk(0, 5, 5, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, "s10_inv"));
    add_nops(3);

    // Reset state
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "idle"));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_a", 32'(hif.fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(hif.fwd_b), 32'd0);
    chk("rst_stall", 32'(hif.stall), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stall_cnt", 32'(hif.stall_cnt), 32'd0);
    chk("rst_fwd_cnt", 32'(hif.fwd_cnt), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-operation: add x5 in MEM, lw x7 in EX, consumer of both in ID
    apply(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, "r_add_x5"));
    apply(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, "r_lw_x7"));
    v = mk(1, 7, 5, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, "r_cons");
    @(negedge clk);
    drive(v);
    #2;
    chk("r_stall_pre", 32'(hif.stall), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("r_fwd_a", 32'(hif.fwd_a), 32'd0);
    chk("r_fwd_b", 32'(hif.fwd_b), 32'd0);
    chk("r_stall", 32'(hif.stall), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("r_stall_cnt", 32'(hif.stall_cnt), 32'd0);
    chk("r_fwd_cnt", 32'(hif.fwd_cnt), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("r_stall_post", 32'(hif.stall), 32'd0);
    @(posedge clk);
    #1;
    chk("r_post_fwd_a", 32'(hif.fwd_a), 32'd0);
    chk("r_post_fwd_b", 32'(hif.fwd_b), 32'd0);

    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "idle"));
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
